step_pulse_gen: RTL and testbench

Converts the debounced push-button level into single-cycle `step` pulses for the lab CPU's single-step and manual-advance logic. It sits directly downstream of the button debouncer and directly upstream of the CPU step/enable input. It generates one pulse per press, auto-repeats while the button is held, and keeps a running count of issued steps.

---
 rtl/step_pkg.sv | 16 +
 rtl/step_edge_detect.sv | 37 +++
 rtl/step_pulse_gen.sv | 123 ++++++++++++
 tb/tb_step_pulse_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// step_pkg: shared types and default timing constants for step_pulse_gen.
//   step_state_t : press FSM state (IDLE / WAIT / REPEAT).
//   *_DEF        : default hold/repeat intervals and the counter width that covers them.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } step_state_t;

  localparam int unsigned HOLD_CYCLES_DEF   = 25_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 5_000_000;
  localparam int unsigned CNT_W_DEF         = 25;

endpackage

// File: rtl/step_edge_detect.sv
// step_edge_detect: registers the debounced button level and flags its rising edge.
//   clk, rst  : clock, async active-high reset
//   btn_level : debounced level (launched on the falling clock edge)
//   btn_q     : registered level
//   rise      : btn_q high while the previous sample was low
// Both sample flops reset high so a button held through reset never looks
// like a fresh press; it has to be released and pressed again.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic btn_q,
  output logic rise
);

  logic btn_d, prev_d, prev_q;

  // The debouncer launches on the falling edge, so this is a half-cycle
  // same-clock path and needs no synchronizer.
  always_comb begin
    btn_d  = btn_level;
    prev_d = btn_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      btn_q  <= btn_d;
      prev_q <= prev_d;
    end
  end

  assign rise = btn_q & ~prev_q;

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns a debounced button level into single-cycle step pulses.
//   clk, rst    : clock, async active-high reset
//   btn_level   : debounced button level
//   en          : step enable; low ignores presses and aborts a hold
//   step        : registered one-cycle pulse per press (plus auto-repeats)
//   held        : registered, high while a press is acknowledged
//   press_count : number of pulses issued, wraps
// Build option STEP_AUTO_REPEAT_EN: when defined, a held button produces a
// repeat pulse HOLD_CYCLES after the first pulse and then every
// REPEAT_CYCLES; when undefined, each press yields exactly one pulse and the
// hold counter is not built.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_level,
  input  logic               en,
  output logic               step,
  output logic               held,
  output logic [COUNT_W-1:0] press_count
);

  logic btn_q, rise;

  step_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .btn_q     (btn_q),
    .rise      (rise)
  );

  step_state_t        state_q, state_d;
  logic               step_q, step_d;
  logic               held_q, held_d;
  logic [COUNT_W-1:0] count_q, count_d;

`ifdef STEP_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise && en) begin
          state_d = WAIT;
          step_d  = 1'b1;
`ifdef STEP_AUTO_REPEAT_EN
          cnt_d   = '0;
`endif
        end
      end
      // Release / disable is tested first so it beats a coincident expiry.
      WAIT: begin
        if (!btn_q || !en) begin
          state_d = IDLE;
        end
`ifdef STEP_AUTO_REPEAT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d = REPEAT;
          step_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef STEP_AUTO_REPEAT_EN
      REPEAT: begin
        if (!btn_q || !en) begin
          state_d = IDLE;
        end else if (cnt_q == REP_LAST) begin
          step_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    held_d  = (state_d == WAIT) || (state_d == REPEAT);
    count_d = step_d ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
      count_q <= '0;
`ifdef STEP_AUTO_REPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      held_q  <= held_d;
      count_q <= count_d;
`ifdef STEP_AUTO_REPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign step        = step_q;
  assign held        = held_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed scenarios plus random presses, checked every
// cycle against a timestamp-based model of the press/auto-repeat rules.
module tb_step_pulse_gen;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int CW   = 4;
`ifdef STEP_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk, rst, btn_level, en;
  logic          step, held;
  logic [CW-1:0] press_count;

  step_pulse_gen #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (4),
    .COUNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .en          (en),
    .step        (step),
    .held        (held),
    .press_count (press_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  int scen_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers the last two sampled levels, whether a press is being
  // held, and when the last pulse went out; a pulse is due once the elapsed
  // cycle count hits the hold interval (first repeat) or repeat interval.
  bit mb_q = 1'b1, mb_prev = 1'b1, m_act = 1'b0, m_first = 1'b0, m_step = 1'b0;
  bit prev_step = 1'b0;
  int m_last = 0, m_cnt = 0, cyc_n = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mb_q = 1'b1; mb_prev = 1'b1; m_act = 1'b0; m_step = 1'b0; m_cnt = 0;
      end else begin
        m_step = 1'b0;
        if (!m_act) begin
          if (mb_q && !mb_prev && en) begin
            m_act = 1'b1; m_step = 1'b1; m_last = cyc_n; m_first = 1'b1;
          end
        end else if (!mb_q || !en) begin
          m_act = 1'b0;
        end else if (AUTO && (cyc_n - m_last == (m_first ? HOLD : REP))) begin
          m_step = 1'b1; m_last = cyc_n; m_first = 1'b0;
        end
        if (m_step) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          scen_pulses++;
        end
        mb_prev = mb_q;
        mb_q    = btn_level;
      end
      cyc_n++;
      #1;
      chk("step", step, m_step);
      chk("held", held, m_act);
      chk("press_count", press_count, m_cnt);
      chk("step_back_to_back", step && prev_step, 0);
      prev_step = step;
    end
  end

  task automatic drive(input logic b, input logic e, input int n);
    repeat (n) begin
      @(negedge clk);
      btn_level = b;
      en        = e;
    end
  endtask

  task automatic start_scen();
    @(negedge clk);
    rst = 1'b1; btn_level = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scen_pulses = 0;
    #1;
    chk("reset_step", step, 0);
    chk("reset_held", held, 0);
    chk("reset_count", press_count, 0);
  endtask

  initial begin
    int target, seen;
    bit hit;
    rst = 1'b1; btn_level = 1'b0; en = 1'b0;

    // 1: short press -> one pulse
    start_scen();
    drive(1, 1, 3); drive(0, 1, 6);
    chk("s1_pulses", scen_pulses, 1);
    chk("s1_count", press_count, 1);

    // 2: long hold -> first pulse, then 8, 12, ..., 28 when auto-repeat is built
    start_scen();
    drive(1, 1, 30); drive(0, 1, 6);
    chk("s2_pulses", scen_pulses, AUTO ? 7 : 1);
    chk("s2_count", press_count, AUTO ? 7 : 1);

    // 3: release lands exactly on hold expiry -> no second pulse
    start_scen();
    drive(1, 1, 8); drive(0, 1, 6);
    chk("s3_pulses", scen_pulses, 1);
    chk("s3_held", held, 0);

    // 4: press while disabled, enable while held -> nothing; new press fires
    start_scen();
    drive(1, 0, 4); drive(1, 1, 4); drive(0, 1, 3);
    chk("s4_no_pulse", scen_pulses, 0);
    drive(1, 1, 3); drive(0, 1, 3);
    chk("s4_pulses", scen_pulses, 1);

    // 5a: button high through reset release -> no pulse
    @(negedge clk);
    rst = 1'b1; btn_level = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scen_pulses = 0;
    drive(1, 1, 5); drive(0, 1, 3);
    chk("s5_held_thru_reset", scen_pulses, 0);

    // 5b: reset while step is high (third pulse = mid-REPEAT when built)
    drive(1, 1, 1);
    target = AUTO ? 3 : 1;
    seen = 0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (m_step) begin
        seen++;
        if (seen == target) hit = 1'b1;
      end
    end
    chk("s5_pulse_found", hit, 1);
    chk("s5_held_before_rst", held, 1);
    rst = 1'b1;
    #1;
    chk("s5_rst_step", step, 0);
    chk("s5_rst_held", held, 0);
    chk("s5_rst_count", press_count, 0);
    @(negedge clk);
    btn_level = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 6: 17 presses wrap a 4-bit press_count to 1
    start_scen();
    repeat (17) begin
      drive(1, 1, 2); drive(0, 1, 2);
    end
    chk("s6_pulses", scen_pulses, 17);
    chk("s6_wrap_count", press_count, 1);

    // random presses with occasional disable
    start_scen();
    repeat (60) begin
      drive(1, ($urandom_range(0, 9) != 0), $urandom_range(1, 22));
      drive(0, ($urandom_range(0, 9) != 0), $urandom_range(1, 5));
    end
    drive(0, 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
